// File: rtl/sigma_delta_pkg.sv
// Shared PCM type, rounding/saturation helpers and defaults for the sigma-delta
// PCM formatter.
package sigma_delta_pkg;

  localparam int PCM_W         = 16;
  localparam int DCB_K_DEFAULT = 10;

  typedef logic signed [PCM_W-1:0] pcm_t;

  // Arithmetic right shift with round-half-up (bias of half an output LSB).
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int                 sh);
    logic signed [63:0] bias;
    bias = '0;
    if (sh > 0) bias = 64'sd1 <<< (sh - 1);
    return (v + bias) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sigma_delta_sample_fifo.sv
// First-word-fall-through sample FIFO: array storage with a registered head
// stage, so a word becomes visible on rd_data the edge after it is written.
module sigma_delta_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    mem_cnt_reg;
  logic [CW-1:0]    mem_cnt_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             pop;
  logic             load;

  // count_reg tracks array + head; mem_cnt_reg tracks only what is left in the array.
  assign pop  = rd_en & head_valid_reg;
  assign load = (mem_cnt_reg != '0) && (!head_valid_reg || pop);

  always_comb begin
    mem_cnt_next = mem_cnt_reg;
    count_next   = count_reg;
    if (wr_en && !load)      mem_cnt_next = mem_cnt_reg + CW'(1);
    else if (!wr_en && load) mem_cnt_next = mem_cnt_reg - CW'(1);
    if (wr_en && !pop)       count_next = count_reg + CW'(1);
    else if (!wr_en && pop)  count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      mem_cnt_reg <= mem_cnt_next;
      count_reg   <= count_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) begin
        head_data_reg  <= mem[rd_ptr_reg];
        head_valid_reg <= 1'b1;
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = !head_valid_reg;
  assign rd_data = head_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/sigma_delta_pcm_formatter.sv
// CIC word -> signed PCM (offset removal, round/shift, saturate) into a FWFT FIFO.
// Optional DC blocker between offset removal and scaling: define SDADC_DC_BLOCK_EN.
module sigma_delta_pcm_formatter
  import sigma_delta_pkg::*;
#(
  parameter int IN_W       = 18,
  parameter int MIDSCALE   = 32768,
  parameter int SHIFT      = 0,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DCB_K      = DCB_K_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam logic signed [IN_W:0] MID_X = (IN_W + 1)'(MIDSCALE);

  // Stage A: offset removal
  logic                   a_valid_reg;
  logic signed [IN_W:0]   x_reg;
  logic signed [IN_W:0]   x_next;

  assign x_next = $signed({1'b0, in_data}) - MID_X;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid_reg <= 1'b0;
      x_reg       <= '0;
    end else begin
      a_valid_reg <= in_valid;
      if (in_valid) x_reg <= x_next;
    end
  end

`ifdef SDADC_DC_BLOCK_EN
  localparam int Y_W = IN_W + DCB_K + 2;

  logic                  d_valid_reg;
  logic signed [IN_W:0]  x_prev_reg;
  logic signed [Y_W-1:0] y_reg;
  logic signed [Y_W-1:0] y_next;
  logic                  sb_valid;
  logic signed [Y_W-1:0] sb_data;

  // One-pole high-pass: y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/2**DCB_K
  assign y_next = Y_W'(x_reg) - Y_W'(x_prev_reg) + y_reg - (y_reg >>> DCB_K);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_reg <= 1'b0;
      x_prev_reg  <= '0;
      y_reg       <= '0;
    end else begin
      d_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        x_prev_reg <= x_reg;
        y_reg      <= y_next;
      end
    end
  end

  assign sb_valid = d_valid_reg;
  assign sb_data  = y_reg;
`else
  logic                  sb_valid;
  logic signed [IN_W:0]  sb_data;

  assign sb_valid = a_valid_reg;
  assign sb_data  = x_reg;
`endif

  // Stage B: scale, round, saturate; its output register is the FIFO write request
  logic                    b_valid_reg;
  logic signed [OUT_W-1:0] b_data_reg;
  logic signed [OUT_W-1:0] b_next;

  assign b_next = OUT_W'(sat_signed(round_shift(64'(sb_data), SHIFT), OUT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid_reg <= 1'b0;
      b_data_reg  <= '0;
    end else begin
      b_valid_reg <= sb_valid;
      if (sb_valid) b_data_reg <= b_next;
    end
  end

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic wr_accept;
  logic ovf_reg;

  assign pop       = out_valid & out_ready;
  assign wr_accept = b_valid_reg & (!fifo_full | pop);

  sigma_delta_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_data (b_data_reg),
    .full    (fifo_full),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fill)
  );

  assign out_valid = !fifo_empty;

  // A dropped sample takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (b_valid_reg && fifo_full && !pop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign ovf = ovf_reg;

endmodule
